// File: rtl/zbt_mbox_pkg.sv
// zbt_mbox_pkg
// Shared definitions for the CPU mailbox to ZBT SRAM responder: bus widths,
// default pipeline latencies of the ZBT part and the responder FSM state type.
// No ports (package).
package zbt_mbox_pkg;

    localparam int unsigned ZBT_AW = 20;
    localparam int unsigned ZBT_DW = 36;

    // Cycles from granted address phase to read data / late-write data on the bus.
    localparam int unsigned ZBT_RD_LAT = 2;
    localparam int unsigned ZBT_WR_LAT = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } mbox_state_t;

endpackage

// File: rtl/zbt_mbox_responder.sv
// zbt_mbox_responder
// Memory-side responder for the CPU ZBT mailbox. Captures one single-word read or
// write from the register-control mailbox, requests a slot from the ZBT arbiter,
// runs the pipelined access and answers with mbox_dval/mbox_rdata or mbox_wdone.
//
// Ports:
//   sys_clk_pin, sys_rst_pin        clock, async active-high reset
//   mbox_sel/we/addr/wdata          mailbox request (level sel, rest sampled at capture)
//   mbox_dval, mbox_wdone           one-cycle completion pulses
//   mbox_rdata                      read data, held until the next read completes
//   zbt_req, zbt_gnt                arbiter handshake; address phase when both high
//   zbt_addr, zbt_we                address phase, valid only while requesting
//   zbt_wdata, zbt_wdata_oe         late-write data and its pad drive enable
//   zbt_rdata                       SRAM read data
module zbt_mbox_responder
    import zbt_mbox_pkg::*;
#(
    // Both latencies must be at least 1.
    parameter int unsigned RD_LAT = ZBT_RD_LAT,
    parameter int unsigned WR_LAT = ZBT_WR_LAT
) (
    input  logic              sys_clk_pin,
    input  logic              sys_rst_pin,
    input  logic              mbox_sel,
    input  logic              mbox_we,
    input  logic [ZBT_AW-1:0] mbox_addr,
    input  logic [ZBT_DW-1:0] mbox_wdata,
    output logic              mbox_dval,
    output logic              mbox_wdone,
    output logic [ZBT_DW-1:0] mbox_rdata,
    output logic              zbt_req,
    input  logic              zbt_gnt,
    output logic [ZBT_AW-1:0] zbt_addr,
    output logic              zbt_we,
    output logic [ZBT_DW-1:0] zbt_wdata,
    output logic              zbt_wdata_oe,
    input  logic [ZBT_DW-1:0] zbt_rdata
);

    localparam int unsigned CNT_W = 8;
    // Counter is loaded with LAT-1 so that it reads 0 exactly in cycle G+LAT.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    mbox_state_t       r_state;
    mbox_state_t       w_state_nxt;
    logic              r_we;
    logic [ZBT_AW-1:0] r_addr;
    logic [ZBT_DW-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [ZBT_DW-1:0] r_rdata;
    logic              r_dval;

    logic              w_capture;
    logic              w_load;
    logic              w_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_done       = 1'b0;
        zbt_req      = 1'b0;
        zbt_addr     = '0;
        zbt_we       = 1'b0;
        zbt_wdata    = '0;
        zbt_wdata_oe = 1'b0;
        mbox_wdone   = 1'b0;

        case (r_state)
            StIdle: begin
                if (mbox_sel) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                zbt_req  = 1'b1;
                zbt_addr = r_addr;
                zbt_we   = r_we;
                // A grant in the same cycle as sel falling wins: the address
                // phase has happened, so the access must run to completion.
                if (zbt_gnt) begin
                    w_load      = 1'b1;
                    w_state_nxt = StWait;
                end else if (!mbox_sel) begin
                    w_state_nxt = StIdle;
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = StHold;
                    if (r_we) begin
                        zbt_wdata    = r_wdata;
                        zbt_wdata_oe = 1'b1;
                        mbox_wdone   = 1'b1;
                    end
                end
            end
            StHold: begin
                if (!mbox_sel) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
        if (sys_rst_pin) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_dval  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_we    <= mbox_we;
                r_addr  <= mbox_addr;
                r_wdata <= mbox_wdata;
            end
            if (w_load) begin
                r_cnt <= r_we ? WR_LOAD : RD_LOAD;
            end else if (r_state == StWait && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Read data lands in the last WAIT cycle; dval follows one cycle later.
            r_dval <= w_done & ~r_we;
            if (w_done && !r_we) begin
                r_rdata <= zbt_rdata;
            end
        end
    end

    assign mbox_dval  = r_dval;
    assign mbox_rdata = r_rdata;

endmodule

// File: doc/zbt_mbox_responder.md
# zbt_mbox_responder

- Memory-side responder for the CPU's ZBT mailbox port.
- Captures one single-word read or write request from the register-control mailbox outputs and requests a slot from the ZBT memory arbiter.
- Issues the access on the pipelined ZBT SRAM and returns either `dval` with `rdata`, or `wdone`, to the mailbox inputs.
- Sits in the GPU clock domain between the register-control block and the ZBT arbiter, so the CPU can peek and poke the frame/z buffer.

## Interface
Parameters:
- `RD_LAT`, 2: cycles from granted read address to `zbt_rdata` valid.
- `WR_LAT`, 2: cycles from granted write address to write data on the bus (ZBT late write).

Ports:
- `sys_clk_pin` in 1: single clock.
- `sys_rst_pin` in 1: reset, asynchronous and active-high.
- `mbox_sel` in 1: level request from CPU mailbox.
- `mbox_we` in 1: 1 = write, 0 = read; sampled at capture.
- `mbox_addr` in 20: word address; sampled at capture.
- `mbox_wdata` in 36: write data; sampled at capture.
- `mbox_dval` out 1: one-cycle pulse, read data valid.
- `mbox_wdone` out 1: one-cycle pulse, write completed.
- `mbox_rdata` out 36: read data; held until the next read completes.
- `zbt_req` out 1: slot request to the arbiter.
- `zbt_gnt` in 1: grant; the address phase occurs in the cycle where `zbt_req & zbt_gnt`.
- `zbt_addr` out 20: address, driven during the grant cycle.
- `zbt_we` out 1: write strobe, driven during the grant cycle.
- `zbt_wdata` out 36: write data.
- `zbt_wdata_oe` out 1: bus drive enable for `zbt_wdata`.
- `zbt_rdata` in 36: SRAM read data.

## Operation
FSM states: IDLE, REQ, WAIT, HOLD.

- **IDLE**
  - If `mbox_sel` is high, capture `we`, `addr` and `wdata` into registers and go to REQ.
- **REQ**
  - `zbt_req` = 1; `zbt_addr` and `zbt_we` are driven from the captured registers.
  - On `zbt_gnt`: load the latency counter with `RD_LAT` or `WR_LAT` (per `we`) and go to WAIT.
  - If `mbox_sel` falls before grant: abort, drop `zbt_req`, return to IDLE, no response pulse.
- **WAIT**
  - Decrement the counter each cycle.
  - Write: in the cycle the counter reaches 0, drive `zbt_wdata` = captured data with `zbt_wdata_oe` = 1, and pulse `mbox_wdone` in that same cycle.
  - Read: in the cycle the counter reaches 0, register `zbt_rdata` into `mbox_rdata`; `mbox_dval` pulses the following cycle.
  - After the pulse, go to HOLD.
  - Once granted, the access always completes, even if `mbox_sel` falls in WAIT.
- **HOLD**
  - Wait for `mbox_sel` = 0, then go to IDLE.
  - Requires the CPU to drop `sel` between transactions; one request per `sel` assertion.
  - If `sel` is already low on entry, go to IDLE the next cycle.
- Outside the stated cycles: `zbt_addr` and `zbt_we` are 0, and `zbt_wdata_oe` = 0.

Reset values:
- All outputs 0, `mbox_rdata` = 0, state = IDLE, counter = 0.
- An asserted reset mid-transaction discards it immediately: no pulse, `zbt_wdata_oe` forced to 0 asynchronously.

## Timing
- Grant cycle G:
  - Write: `wdata_oe` and `wdone` at G+`WR_LAT`.
  - Read: `zbt_rdata` sampled at G+`RD_LAT`, `mbox_dval` at G+`RD_LAT`+1.
- Minimum latency from the `sel` rise at cycle S with immediate grant:
  - Capture at the edge ending S, so REQ occupies S+1 and G = S+1.
  - Read `dval` at S+4 with defaults; write `wdone` at S+3.
- `zbt_req` is held continuously until grant. Grant is only honoured in REQ; a `zbt_gnt` in any other state is ignored.
- `mbox_dval` and `mbox_wdone` are never high together, and never high for more than one cycle.
- Back-to-back transactions: `sel` low for at least 1 cycle, then high → the next capture occurs on the first IDLE cycle with `sel` high.

## Structure
- A shared package `zbt_mbox_pkg` holds:
  - `ZBT_AW` = 20, `ZBT_DW` = 36.
  - The state enum `mbox_state_t`.
  - Default latencies `ZBT_RD_LAT` and `ZBT_WR_LAT`.
- The FSM, counter and capture registers are a single module; no sub-module.
- The ZBT arbiter and its pad tristate stay external.

## Test plan
- **Write with immediate grant:**
  - Stimulus: `sel`=1, `we`=1, `addr`=0x00123, `wdata`=0x9ABCDEF01, `gnt` tied 1.
  - Response: `zbt_addr`=0x00123 and `we`=1 at S+1; `wdata_oe`=1 with `wdata`=0x9ABCDEF01 and a single `wdone` at S+3.
- **Read with delayed grant:**
  - Stimulus: `addr`=0xFFFFF, `we`=0, `gnt` asserted at S+5; model returns 0xA5A5A5A5A at G+2.
  - Response: `req` high S+1..S+5; `dval` at G+3 with `rdata`=0xA5A5A5A5A, held after the pulse.
- **Abort before grant:**
  - Stimulus: `sel` drops at S+3, `gnt`=0 throughout.
  - Response: `req` falls by S+4; no `wdone`, no `dval`, no `wdata_oe`; a later request works normally.
- **Sel held high after completion:**
  - Stimulus: keep `sel`=1 for 20 cycles after `dval`.
  - Response: exactly one transaction. Drop `sel` for 1 cycle, raise it again → a second transaction issues.
- **Reset mid-WAIT:**
  - Stimulus: assert `sys_rst_pin` asynchronously one cycle after a write grant.
  - Response: `wdata_oe` and `wdone` are 0 immediately, state returns to IDLE, no pulse after release.
- **Parameter sweep:**
  - Stimulus: `RD_LAT`=3, `WR_LAT`=1.
  - Response: `dval` at G+4, `wdone` at G+1; `rdata` sampled at exactly G+3 (the model changes data at G+2 and G+4).
